rns_add_sequencer: RTL and testbench

Time-multiplexed controller for three-channel residue-number-system (RNS) addition. It accepts one operand pair per transaction over a valid/ready handshake, then sequences a single shared single-channel modular adder across the three moduli channels, one channel per cycle. It also holds the three moduli in configuration registers, and supports an accumulate mode in which the previous result replaces operand A. It sits between the operand source and the RNS result consumer, replacing three parallel modular adders with one.

---
 rtl/rns_pkg.sv | 8 +
 rtl/rns_add_sequencer_adder.sv | 17 +
 rtl/rns_add_sequencer.sv | 94 +++++++++
 tb/tb_rns_add_sequencer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// rns_pkg: shared width, reset moduli and FSM states for the RNS add sequencer.
package rns_pkg;
    localparam int RES_W = 3;
    localparam int MOD1_RST = 7;
    localparam int MOD2_RST = 5;
    localparam int MOD3_RST = 3;
    typedef enum logic [2:0] {IDLE, CH1, CH2, CH3, DONE} state_t;
endpackage

// File: rtl/rns_add_sequencer_adder.sv
// Adder_moduli_single: one-channel modular adder with operand range check.
module Adder_moduli_single #(
    parameter int RES_W = 3
) (
    input  logic [RES_W-1:0] a,
    input  logic [RES_W-1:0] b,
    input  logic [RES_W-1:0] m,
    output logic [RES_W-1:0] sum,
    output logic             bad
);
    logic [RES_W:0] s;
    logic [RES_W:0] d;
    assign s   = {1'b0, a} + {1'b0, b};
    assign d   = s - {1'b0, m};
    assign sum = s >= {1'b0, m} ? d[RES_W-1:0] : s[RES_W-1:0];
    assign bad = a >= m || b >= m;
endmodule

// File: rtl/rns_add_sequencer.sv
// rns_add_sequencer: time-multiplexes one modular adder over three RNS channels.
module rns_add_sequencer #(
    parameter int RES_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [RES_W-1:0] cfg_mod1,
    input  logic [RES_W-1:0] cfg_mod2,
    input  logic [RES_W-1:0] cfg_mod3,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_acc,
    input  logic [RES_W-1:0] a1,
    input  logic [RES_W-1:0] a2,
    input  logic [RES_W-1:0] a3,
    input  logic [RES_W-1:0] b1,
    input  logic [RES_W-1:0] b2,
    input  logic [RES_W-1:0] b3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] sum1,
    output logic [RES_W-1:0] sum2,
    output logic [RES_W-1:0] sum3,
    output logic             err,
    output logic [RES_W-1:0] mod1,
    output logic [RES_W-1:0] mod2,
    output logic [RES_W-1:0] mod3
);
    import rns_pkg::*;

    state_t state, state_next;
    logic [RES_W-1:0] a_in [3];
    logic [RES_W-1:0] a_r [3];
    logic [RES_W-1:0] b_r [3];
    logic [RES_W-1:0] s_r [3];
    logic [RES_W-1:0] acc [3];
    logic [RES_W-1:0] m_r [3];
    logic             err_r, accept, fire, cfg_ok, ch_active, add_bad;
    logic [1:0]       ch;
    logic [RES_W-1:0] add_s;

    assign a_in      = '{a1, a2, a3};
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_ready && in_valid;
    assign fire      = out_valid && out_ready;
    assign cfg_ok    = in_ready && cfg_we && !in_valid && cfg_mod1 > RES_W'(1)
                       && cfg_mod2 > RES_W'(1) && cfg_mod3 > RES_W'(1);
    assign ch_active = state == CH1 || state == CH2 || state == CH3;
    assign ch        = state == CH2 ? 2'd1 : state == CH3 ? 2'd2 : 2'd0;
    assign {sum1, sum2, sum3} = {s_r[0], s_r[1], s_r[2]};
    assign {mod1, mod2, mod3} = {m_r[0], m_r[1], m_r[2]};
    assign err = err_r;

    Adder_moduli_single #(.RES_W(RES_W)) u_add (
        .a(a_r[ch]), .b(b_r[ch]), .m(m_r[ch]), .sum(add_s), .bad(add_bad)
    );

    always_comb begin
        state_next = state;
        state_next = accept ? CH1 : state == CH1 ? CH2 : state == CH2 ? CH3 :
                     state == CH3 ? DONE : fire ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            err_r <= 1'b0;
            s_r   <= '{default: '0};
            acc   <= '{default: '0};
            m_r   <= '{RES_W'(MOD1_RST), RES_W'(MOD2_RST), RES_W'(MOD3_RST)};
        end else begin
            state <= state_next;
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    a_r[i] <= in_acc ? acc[i] : a_in[i];
                end
                b_r <= '{b1, b2, b3};
            end
            if (ch_active) begin
                s_r[ch] <= add_s;
                if (add_bad) err_r <= 1'b1;
            end
            // an errored result is presented as all-zero sums
            if (state == CH3 && (err_r || add_bad)) s_r <= '{default: '0};
            if (fire) begin
                if (!err_r) acc <= s_r;
                err_r <= 1'b0;
            end
            if (cfg_ok) m_r <= '{cfg_mod1, cfg_mod2, cfg_mod3};
        end
    end
endmodule

// File: tb/tb_rns_add_sequencer.sv
// tb_rns_add_sequencer: directed-vector self-checking bench for rns_add_sequencer.
module tb_rns_add_sequencer;
    logic       clk = 0, rst_n = 0, cfg_we = 0, in_valid = 0, in_acc = 0, out_ready = 1;
    logic [2:0] cfg_mod1 = 0, cfg_mod2 = 0, cfg_mod3 = 0;
    logic [2:0] a1 = 0, a2 = 0, a3 = 0, b1 = 0, b2 = 0, b3 = 0;
    logic       in_ready, out_valid, err;
    logic [2:0] sum1, sum2, sum3, mod1, mod2, mod3;
    int         n_cmp = 0, n_bad = 0;

    rns_add_sequencer #(.RES_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we),
        .cfg_mod1(cfg_mod1), .cfg_mod2(cfg_mod2), .cfg_mod3(cfg_mod3),
        .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
        .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum1(sum1), .sum2(sum2), .sum3(sum3), .err(err),
        .mod1(mod1), .mod2(mod2), .mod3(mod3)
    );

    always #5 clk = ~clk;

    // residue triples are compared and printed in octal, one digit per channel
    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    // mode 0: plain; 1: cfg_we alongside in_valid; 2: cfg_we during CH2
    task automatic xact(input string tag, input bit acc, input logic [8:0] a, input logic [8:0] b,
                        input logic [8:0] e, input bit ee, input int mode);
        int n;
        @(negedge clk);
        check({tag, " in_ready"}, in_ready, 1);
        in_valid = 1; in_acc = acc;
        {a1, a2, a3} = a; {b1, b2, b3} = b;
        cfg_we = mode == 1; {cfg_mod1, cfg_mod2, cfg_mod3} = {3'd6, 3'd4, 3'd3};
        @(negedge clk);
        in_valid = 0; in_acc = 0; cfg_we = 0; n = 1;
        while (!out_valid && n < 20) begin
            cfg_we = mode == 2 && n == 2;
            @(negedge clk);
            n++;
        end
        cfg_we = 0;
        check({tag, " latency"}, n, 4);
        check({tag, " sum"}, {sum1, sum2, sum3}, e);
        check({tag, " err"}, err, ee);
        @(negedge clk);
        check({tag, " out_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        rst_n = 1;
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst sum", {sum1, sum2, sum3}, 0);
        check("rst err", err, 0);
        check("rst mods", {mod1, mod2, mod3}, 'o753);

        xact("basic", 0, 'o432, 'o542, 'o221, 0, 0);
        xact("range_err", 0, 'o700, 'o000, 'o000, 1, 0);
        xact("acc_kept", 1, 'o000, 'o000, 'o221, 0, 0);
        xact("chain0", 0, 'o111, 'o111, 'o222, 0, 0);
        xact("chain1", 1, 'o000, 'o642, 'o111, 0, 0);
        xact("chain2", 1, 'o000, 'o642, 'o000, 0, 0);

        out_ready = 0;
        @(negedge clk);
        in_valid = 1; {a1, a2, a3} = 'o321; {b1, b2, b3} = 'o111;
        @(negedge clk);
        in_valid = 0;
        repeat (3) @(negedge clk);
        in_valid = 1; {a1, a2, a3} = 'o100; {b1, b2, b3} = 'o000;
        for (int i = 0; i < 10; i++) begin
            check("bp out_valid", out_valid, 1);
            check("bp in_ready", in_ready, 0);
            check("bp sum", {sum1, sum2, sum3}, 'o432);
            @(negedge clk);
        end
        out_ready = 1;
        @(negedge clk);
        check("bp released out_valid", out_valid, 0);
        check("bp released in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        check("bp second accepted", in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp second sum", {sum1, sum2, sum3}, 'o100);
        @(negedge clk);

        cfg_we = 1; {cfg_mod1, cfg_mod2, cfg_mod3} = {3'd5, 3'd3, 3'd2};
        @(negedge clk);
        cfg_we = 0;
        check("cfg write", {mod1, mod2, mod3}, 'o532);
        xact("cfg add", 0, 'o421, 'o321, 'o210, 0, 0);
        cfg_we = 1; {cfg_mod1, cfg_mod2, cfg_mod3} = {3'd6, 3'd4, 3'd1};
        @(negedge clk);
        cfg_we = 0;
        check("cfg mod<2 ignored", {mod1, mod2, mod3}, 'o532);
        xact("cfg in CH2", 0, 'o111, 'o111, 'o220, 0, 2);
        check("cfg CH2 ignored", {mod1, mod2, mod3}, 'o532);
        xact("cfg with valid", 0, 'o111, 'o000, 'o111, 0, 1);
        check("cfg with valid ignored", {mod1, mod2, mod3}, 'o532);

        @(negedge clk);
        in_valid = 1; {a1, a2, a3} = 'o111; {b1, b2, b3} = 'o111;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        check("midrst out_valid", out_valid, 0);
        check("midrst in_ready", in_ready, 1);
        check("midrst sum", {sum1, sum2, sum3}, 0);
        check("midrst err", err, 0);
        check("midrst mods", {mod1, mod2, mod3}, 'o753);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst no out_valid", out_valid, 0);
        end
        xact("midrst acc cleared", 1, 'o000, 'o222, 'o222, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
